mem_wb_pipe_reg: RTL and testbench
==================================

# mem_wb_pipe_reg

Parametrised MEM→WB pipeline register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It sits between the memory-access stage and the write-back stage. It carries the write-back control bits, the ALU result, the memory read value and the destination register. It also presents the pre-selected write-back value, so WB and forwarding logic get a ready-to-use operand.

## Interface
Parameters:
- DATA_W, 32, width of the ALU result, memory read value and write-back value
- DEST_W, 5, width of the destination register index

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  register accepts an entry this cycle
- in_wb_en  in  1  entry writes the register file
- in_mem_r_en  in  1  entry is a load
- in_alu_res  in  DATA_W  ALU result / address
- in_mem_data  in  DATA_W  data-memory read value
- in_dest  in  DEST_W  destination register index
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB stage consumes the entry
- out_wb_en, out_mem_r_en  out  1 each  registered controls, forced 0 when out_valid=0
- out_alu_res, out_mem_data  out  DATA_W each  registered payload
- out_dest  out  DEST_W  registered destination
- out_wb_value  out  DATA_W  out_mem_r_en ? out_mem_data : out_alu_res
- occupancy  out  2  number of held entries (0..2; 0..1 without skid)

## Operation
- Accept condition: in_valid && in_ready. Consume condition: out_valid && out_ready.
- Main entry: drives all out_* signals. Skid entry: holds one overflow entry (SKID mode only).
- SKID mode, state by occupancy:
  - EMPTY: on accept → ONE, entry loads into main.
  - ONE: accept + consume → stays ONE, main is replaced. Accept without consume → FULL, entry loads into skid. Consume without accept → EMPTY.
  - FULL: in_ready=0. On consume, skid moves to main → ONE.
- Entry order is strictly preserved. No entry is lost or duplicated.
- Payload registers are load-enabled. In EMPTY they hold their last data, but out_wb_en and out_mem_r_en read 0.
- flush: next state is EMPTY regardless of in_valid and out_ready. An accept in the same cycle as flush is discarded. Payload data registers are not cleared.
- An entry with in_wb_en=0 is still a valid entry. It is transported and consumed normally.
- out_wb_value is combinational from the main entry only.

## Timing
- Reset: all outputs and internal registers are 0. occupancy=0, out_valid=0, in_ready=1 (SKID mode) on the first cycle after reset release.
- Latency: an entry accepted at edge N appears on out_* after edge N, provided main was empty or consumed at edge N.
- SKID mode:
  - in_ready is a registered signal and equals (occupancy != 2). It has no combinational path from out_ready.
  - Sustained throughput is 1 entry/cycle.
- Reset asserted mid-operation: state returns to EMPTY immediately (asynchronously). Held entries are dropped.
- flush has priority over accept and consume in the same cycle.

## Configuration
- Macro MEM_WB_PIPE_SKID_EN.
- Defined: two-entry skid buffer as above. in_ready is registered. occupancy ranges 0..2.
- Undefined:
  - Single entry only; the skid register is not built.
  - in_ready = !out_valid || out_ready, combinational from out_ready.
  - occupancy[1] is tied to 0.
  - flush, latency and reset behaviour are unchanged.

## Test plan
- Reset release, then accept in_alu_res=0x0000_1234, in_dest=5, in_wb_en=1, out_ready=1 → next cycle out_valid=1, out_dest=5, out_wb_value=0x0000_1234. The following cycle out_valid=0, out_wb_en=0.
- Load entry in_mem_r_en=1, in_mem_data=0xDEAD_BEEF, in_alu_res=0x10 → out_wb_value=0xDEAD_BEEF.
- SKID_EN: out_ready=0, push A=1 then B=2 → occupancy=2, in_ready=0 on the third cycle. Raise out_ready → out_alu_res=1 then 2 on consecutive cycles, in_ready=1 one cycle after the first consume.
- Back-to-back stream of 8 entries 0..7 with out_ready=1 → 8 consecutive out_valid cycles, values in order, in_ready never drops.
- Occupancy 2, then flush=1 with in_valid=1, in_alu_res=9 → next cycle occupancy=0, out_valid=0, value 9 never appears.
- Assert rst for 1 cycle while occupancy=1 → out_valid=0, all outputs 0 immediately, normal accept on the next cycle after release.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, synchronous flush and
// an optional two-entry skid buffer enabled by the MEM_WB_PIPE_SKID_EN macro.
module mem_wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_wb_value,
  output logic [1:0]        occupancy
);

  // Handshake: an entry moves on a cycle where valid && ready are both high at
  // the clock edge; valid never depends on ready, and a held entry stays stable
  // until it is consumed.
  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_data;
    logic [DEST_W-1:0] dest;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t in_entry, main_q;
  logic   accept, consume, load_main;

  assign in_entry = '{wb_en: in_wb_en, mem_r_en: in_mem_r_en, alu_res: in_alu_res,
                      mem_data: in_mem_data, dest: in_dest};
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

`ifdef MEM_WB_PIPE_SKID_EN
  entry_t skid_q;
  logic   load_skid, main_from_skid;

  // Ready comes straight from state, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != S_FULL);
  assign occupancy = state_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
          state_d   = S_ONE;
          load_main = 1'b1;
        end
        S_ONE: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = S_FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: if (consume) begin
          state_d        = S_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= main_from_skid ? skid_q : in_entry;
    end
  end
`else
  assign in_ready  = (state_q == S_EMPTY) || out_ready;
  assign occupancy = {1'b0, state_q == S_ONE};

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d   = S_ONE;
      load_main = 1'b1;
    end else if (consume) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= in_entry;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Controls are masked when empty; payload keeps its last loaded value.
  assign out_wb_en    = out_valid && main_q.wb_en;
  assign out_mem_r_en = out_valid && main_q.mem_r_en;
  assign out_alu_res  = main_q.alu_res;
  assign out_mem_data = main_q.mem_data;
  assign out_dest     = main_q.dest;
  assign out_wb_value = out_mem_r_en ? main_q.mem_data : main_q.alu_res;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed self-checking bench for mem_wb_pipe_reg; follows MEM_WB_PIPE_SKID_EN
// to select the expectations for the skid or single-entry build.
module tb_mem_wb_pipe_reg;
  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_wb_en = 1'b0;
  logic              in_mem_r_en = 1'b0;
  logic [DATA_W-1:0] in_alu_res = '0;
  logic [DATA_W-1:0] in_mem_data = '0;
  logic [DEST_W-1:0] in_dest = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_wb_en;
  logic              out_mem_r_en;
  logic [DATA_W-1:0] out_alu_res;
  logic [DATA_W-1:0] out_mem_data;
  logic [DEST_W-1:0] out_dest;
  logic [DATA_W-1:0] out_wb_value;
  logic [1:0]        occupancy;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  mem_wb_pipe_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_wb_en(in_wb_en),
    .in_mem_r_en(in_mem_r_en), .in_alu_res(in_alu_res), .in_mem_data(in_mem_data),
    .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_alu_res(out_alu_res),
    .out_mem_data(out_mem_data), .out_dest(out_dest), .out_wb_value(out_wb_value),
    .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_entry(input logic wb, input logic ld, input logic [DATA_W-1:0] alu,
                             input logic [DATA_W-1:0] data, input logic [DEST_W-1:0] dst);
    in_valid    = 1'b1;
    in_wb_en    = wb;
    in_mem_r_en = ld;
    in_alu_res  = alu;
    in_mem_data = data;
    in_dest     = dst;
  endtask

  task automatic drive_idle();
    in_valid    = 1'b0;
    in_wb_en    = 1'b0;
    in_mem_r_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b occupancy=%0d required 0/0", out_valid, occupancy);
    end
    checks++;
    if (out_alu_res !== '0 || out_wb_value !== '0 || out_dest !== '0 || out_wb_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: alu=%h wbv=%h dest=%0d wb_en=%b required zeros",
               out_alu_res, out_wb_value, out_dest, out_wb_en);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b occupancy=%0d required 1/0", in_ready, occupancy);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_entry(1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    step();
    drive_idle();
    checks++;
    if (out_valid !== 1'b1 || out_dest !== 5'd5 || out_wb_value !== 32'h0000_1234 || out_wb_en !== 1'b1) begin
      errors++;
      $display("FAIL basic_out: valid=%b dest=%0d wbv=%h wb_en=%b required 1/5/00001234/1",
               out_valid, out_dest, out_wb_value, out_wb_en);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_wb_en !== 1'b0 || out_alu_res !== 32'h0000_1234) begin
      errors++;
      $display("FAIL basic_drain: valid=%b wb_en=%b alu=%h required 0/0/00001234",
               out_valid, out_wb_en, out_alu_res);
    end
  endtask

  task automatic test_load();
    out_ready = 1'b0;
    drive_entry(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd9);
    step();
    drive_idle();
    checks++;
    if (out_wb_value !== 32'hDEAD_BEEF || out_mem_r_en !== 1'b1 || out_alu_res !== 32'h10) begin
      errors++;
      $display("FAIL load_value: wbv=%h mem_r_en=%b alu=%h required deadbeef/1/10",
               out_wb_value, out_mem_r_en, out_alu_res);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_mem_r_en !== 1'b0 || out_wb_value !== 32'h10) begin
      errors++;
      $display("FAIL load_drain: valid=%b mem_r_en=%b wbv=%h required 0/0/10",
               out_valid, out_mem_r_en, out_wb_value);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_entry(1'b1, 1'b0, 32'd1, 32'h0, 5'd1);
    step();
    drive_entry(1'b1, 1'b0, 32'd2, 32'h0, 5'd2);
`ifdef MEM_WB_PIPE_SKID_EN
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_one: in_ready=%b occupancy=%0d required 1/1", in_ready, occupancy);
    end
    step();
    drive_idle();
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_alu_res !== 32'd1) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b occupancy=%0d alu=%0d required 0/2/1",
               in_ready, occupancy, out_alu_res);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_registered: in_ready=%b required 0", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_alu_res !== 32'd2 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_second: valid=%b alu=%0d in_ready=%b occupancy=%0d required 1/2/1/1",
               out_valid, out_alu_res, in_ready, occupancy);
    end
`else
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_stall: in_ready=%b occupancy=%0d required 0/1", in_ready, occupancy);
    end
    step();
    checks++;
    if (out_alu_res !== 32'd1 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_hold: alu=%0d occupancy=%0d required 1/1", out_alu_res, occupancy);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_comb: in_ready=%b required 1", in_ready);
    end
    step();
    drive_idle();
    checks++;
    if (out_valid !== 1'b1 || out_alu_res !== 32'd2) begin
      errors++;
      $display("FAIL bp_second: valid=%b alu=%0d required 1/2", out_valid, out_alu_res);
    end
`endif
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b occupancy=%0d required 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_v;
    out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive_entry(i[0], 1'b0, DATA_W'(i), 32'hFFFF_0000, DEST_W'(i));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, in_ready);
      end
      exp_q.push_back(DATA_W'(i));
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_alu_res !== exp_v || out_wb_en !== exp_v[0]) begin
        errors++;
        $display("FAIL b2b_data[%0d]: valid=%b alu=%0d wb_en=%b required 1/%0d/%b",
                 i, out_valid, out_alu_res, out_wb_en, exp_v, exp_v[0]);
      end
    end
    drive_idle();
    step();
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: valid=%b pending=%0d required 0/0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_flush();
    logic [1:0] exp_occ;
    out_ready = 1'b0;
    drive_entry(1'b1, 1'b0, 32'd1, 32'h0, 5'd1);
    step();
`ifdef MEM_WB_PIPE_SKID_EN
    drive_entry(1'b1, 1'b0, 32'd2, 32'h0, 5'd2);
    step();
    exp_occ = 2'd2;
`else
    exp_occ = 2'd1;
`endif
    checks++;
    if (occupancy !== exp_occ) begin
      errors++;
      $display("FAIL flush_pre: occupancy=%0d required %0d", occupancy, exp_occ);
    end
    flush = 1'b1;
    drive_entry(1'b1, 1'b0, 32'd9, 32'h0, 5'd9);
    step();
    flush = 1'b0;
    drive_idle();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_wb_en !== 1'b0 || out_alu_res !== 32'd1) begin
      errors++;
      $display("FAIL flush_state: occ=%0d valid=%b wb_en=%b alu=%0d required 0/0/0/1",
               occupancy, out_valid, out_wb_en, out_alu_res);
    end
    out_ready = 1'b1;
    repeat (2) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_alu_res === 32'd9) begin
        errors++;
        $display("FAIL flush_after: valid=%b alu=%0d required 0/not 9", out_valid, out_alu_res);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_entry(1'b1, 1'b1, 32'h0000_00AA, 32'h0000_00BB, 5'd7);
    step();
    drive_idle();
    checks++;
    if (occupancy !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_pre: occupancy=%0d required 1", occupancy);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_alu_res !== '0 || out_mem_data !== '0 ||
        out_dest !== '0 || out_wb_value !== '0 || out_mem_r_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b occ=%0d alu=%h data=%h dest=%0d wbv=%h required zeros",
               out_valid, occupancy, out_alu_res, out_mem_data, out_dest, out_wb_value);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive_entry(1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd3);
    step();
    drive_idle();
    checks++;
    if (out_valid !== 1'b1 || out_alu_res !== 32'h55 || out_dest !== 5'd3) begin
      errors++;
      $display("FAIL rstmid_accept: valid=%b alu=%h dest=%0d required 1/55/3",
               out_valid, out_alu_res, out_dest);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
